// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M multiply/divide unit (shift-add / restoring division, one bit per cycle)
module alu_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            md_valid_i,
  output logic            md_ready_o,
  input  logic [2:0]      md_op_i,
  input  logic [XLEN-1:0] md_data1_i,
  input  logic [XLEN-1:0] md_data2_i,
  input  logic            md_flush_i,
  output logic            md_valid_o,
  input  logic            md_ready_i,
  output logic [XLEN-1:0] md_result_o,
  output logic            md_busy_o
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   b_q, b_d, result_q, result_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              accept, sgn1, sgn2, div_zero, div_ovf;
  logic [XLEN-1:0]   mag1, mag2, div_res;
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] step, prod;
  assign md_ready_o  = state_q == IDLE && !rst;
  assign md_valid_o  = state_q == DONE;
  assign md_busy_o   = state_q != IDLE;
  assign md_result_o = result_q;
  assign accept      = md_valid_i && md_ready_o && !md_flush_i;
  // rs1 is unsigned for MULHU/DIVU/REMU; rs2 additionally unsigned for MULHSU
  assign sgn1     = md_data1_i[XLEN-1] && !(md_op_i[0] && md_op_i[2:1] != 2'b00);
  assign sgn2     = md_data2_i[XLEN-1] && !(md_op_i[0] && md_op_i[2:1] != 2'b00) && md_op_i != 3'b010;
  assign mag1     = sgn1 ? -md_data1_i : md_data1_i;
  assign mag2     = sgn2 ? -md_data2_i : md_data2_i;
  assign div_zero = md_op_i[2] && md_data2_i == '0;
  assign div_ovf  = md_op_i[2] && !md_op_i[0] && md_data1_i == {1'b1, {(XLEN-1){1'b0}}} && &md_data2_i;
  // acc holds {product_hi, multiplier} for multiply and {remainder, quotient} for divide
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff = div_sh - {1'b0, b_q};
  assign step     = op_q[2] ? (div_diff[XLEN] ? {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                              : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1})
                            : {mul_sum, acc_q[XLEN-1:1]};
  assign prod     = neg_q ? -step : step;
  assign div_res  = op_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    if (md_flush_i) begin
      state_d = IDLE;
    end else if (accept) begin
      op_d     = md_op_i;
      neg_d    = md_op_i == 3'b110 ? sgn1 : sgn1 ^ sgn2;
      cnt_d    = CW'(XLEN-1);
      b_d      = md_op_i[2] ? mag2 : mag1;
      acc_d    = {{XLEN{1'b0}}, md_op_i[2] ? mag1 : mag2};
      state_d  = div_zero || div_ovf ? DONE : BUSY;
      result_d = div_zero ? (md_op_i[1] ? md_data1_i : '1) : div_ovf ? (md_op_i[1] ? '0 : md_data1_i) : result_q;
    end else if (state_q == BUSY) begin
      acc_d = step;
      cnt_d = cnt_q != '0 ? cnt_q - CW'(1) : cnt_q;
      if (cnt_q == '0) begin
        state_d  = DONE;
        result_d = op_q[2] ? (neg_q ? -div_res : div_res)
                           : (op_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
      end
    end else if (state_q == DONE && md_ready_i) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed and randomized checks of alu_muldiv against a plain-arithmetic RV32M model
module tb_alu_muldiv;
  logic        clk = 1'b0, rst = 1'b1, md_valid_i = 1'b0, md_flush_i = 1'b0, md_ready_i = 1'b0;
  logic [2:0]  md_op_i = '0;
  logic [31:0] md_data1_i = '0, md_data2_i = '0, md_result_o;
  logic        md_ready_o, md_valid_o, md_busy_o;
  int          compared = 0, mismatched = 0;
  logic        seen;
  always #5 clk = ~clk;
  alu_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .md_valid_i(md_valid_i), .md_ready_o(md_ready_o), .md_op_i(md_op_i),
    .md_data1_i(md_data1_i), .md_data2_i(md_data2_i), .md_flush_i(md_flush_i),
    .md_valid_o(md_valid_o), .md_ready_i(md_ready_i), .md_result_o(md_result_o), .md_busy_o(md_busy_o)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub, q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin q = sa / sb; p = q; return b == 0 ? 32'hffffffff : p[31:0]; end
      3'd5: return b == 0 ? 32'hffffffff : a / b;
      3'd6: begin q = sa % sb; p = q; return b == 0 ? a : p[31:0]; end
      default: return b == 0 ? a : a % b;
    endcase
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hffffffff;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction
  // Entered and left on a falling edge; the request is presented immediately.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    int n;
    logic [31:0] e;
    logic spec;
    spec = op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hffffffff));
    e = ref_md(op, a, b);
    chk("ready_before_req", md_ready_o, 1);
    md_valid_i = 1; md_op_i = op; md_data1_i = a; md_data2_i = b;
    @(negedge clk);
    md_valid_i = 0; md_op_i = 3'($urandom); md_data1_i = $urandom; md_data2_i = $urandom;
    n = 1;
    while (!md_valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("latency op%0d %h,%h", op, a, b), 64'(n), spec ? 64'd1 : 64'd33);
    chk($sformatf("result op%0d %h,%h", op, a, b), md_result_o, e);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", md_valid_o, 1);
      chk("hold_result", md_result_o, e);
      chk("hold_ready_o", md_ready_o, 0);
    end
    md_ready_i = 1;
    @(negedge clk);
    md_ready_i = 0;
    chk("valid_drop", md_valid_o, 0);
    chk("ready_rise", md_ready_o, 1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", md_ready_o, 0);
    chk("rst_valid", md_valid_o, 0);
    chk("rst_result", md_result_o, 0);
    chk("rst_busy", md_busy_o, 0);
    rst = 0;
    @(negedge clk);
    do_op(3'd0, 32'd7, 32'hfffffffd, 0);
    chk("mul_spec", md_result_o, 32'hffffffeb);
    do_op(3'd1, 32'h80000000, 32'h80000000, 0);
    chk("mulh_spec", md_result_o, 32'h40000000);
    do_op(3'd3, 32'hffffffff, 32'hffffffff, 0);
    chk("mulhu_spec", md_result_o, 32'hfffffffe);
    do_op(3'd2, 32'hffffffff, 32'd2, 1);
    chk("mulhsu_spec", md_result_o, 32'hffffffff);
    do_op(3'd4, 32'hfffffff9, 32'd2, 0);
    chk("div_spec", md_result_o, 32'hfffffffd);
    do_op(3'd6, 32'hfffffff9, 32'd2, 0);
    chk("rem_spec", md_result_o, 32'hffffffff);
    do_op(3'd5, 32'd100, 32'd7, 0);
    do_op(3'd7, 32'd100, 32'd7, 0);
    do_op(3'd4, 32'd5, 32'd0, 0);
    do_op(3'd6, 32'd5, 32'd0, 0);
    do_op(3'd4, 32'h80000000, 32'hffffffff, 0);
    do_op(3'd6, 32'h80000000, 32'hffffffff, 0);
    do_op(3'd5, 32'd100, 32'd7, 10);
    // reset in BUSY cycle 5
    md_valid_i = 1; md_op_i = 3'd0; md_data1_i = 32'd9; md_data2_i = 32'd9;
    @(negedge clk);
    md_valid_i = 0;
    repeat (4) @(negedge clk);
    chk("busy_before_rst", md_busy_o, 1);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_ready", md_ready_o, 0);
    chk("rst_mid_busy", md_busy_o, 0);
    chk("rst_mid_result", md_result_o, 0);
    rst = 0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      seen |= md_valid_o | md_busy_o;
    end
    chk("rst_no_valid", seen, 0);
    // flush in BUSY cycle 10 with a request presented in the same cycle
    md_valid_i = 1; md_op_i = 3'd1; md_data1_i = 32'd5; md_data2_i = 32'd6;
    @(negedge clk);
    md_valid_i = 0;
    repeat (9) @(negedge clk);
    chk("busy_before_flush", md_busy_o, 1);
    md_flush_i = 1; md_valid_i = 1;
    @(negedge clk);
    md_flush_i = 0; md_valid_i = 0;
    chk("flush_busy", md_busy_o, 0);
    chk("flush_valid", md_valid_o, 0);
    chk("flush_ready", md_ready_o, 1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      seen |= md_valid_o | md_busy_o;
    end
    chk("flush_no_valid", seen, 0);
    do_op(3'd0, 32'd3, 32'd4, 0);
    chk("mul_after_flush", md_result_o, 32'd12);
    // flush in DONE together with md_ready_i
    md_valid_i = 1; md_op_i = 3'd4; md_data1_i = 32'd5; md_data2_i = 32'd0;
    @(negedge clk);
    md_valid_i = 0;
    chk("done_before_flush", md_valid_o, 1);
    md_flush_i = 1; md_ready_i = 1;
    @(negedge clk);
    md_flush_i = 0; md_ready_i = 0;
    chk("flush_done_valid", md_valid_o, 0);
    chk("flush_done_busy", md_busy_o, 0);
    // flush in IDLE blocks a simultaneous request
    md_flush_i = 1; md_valid_i = 1; md_op_i = 3'd0;
    @(negedge clk);
    md_flush_i = 0; md_valid_i = 0;
    chk("flush_idle_busy", md_busy_o, 0);
    chk("flush_idle_valid", md_valid_o, 0);
    for (int i = 0; i < 40; i++) do_op(3'($urandom), pick(), pick(), $urandom_range(0, 3));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
